memory_stage: RTL

Memory (M) stage of the five-stage RV32 pipeline, directly downstream of the execute stage. It consumes the EX/MEM register contents, performs byte/half/word loads and stores against an internal data memory, and selects the write-back value. It also holds the MEM/WB pipeline register, which drives the register-file write port and the forwarding paths back into execute.

---
 rtl/memory_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory stage of the RV32 pipeline: byte/half/word loads and stores against internal data memory, write-back select, MEM/WB register.
// Latency: memfwd is combinational; regwritew/rdw/resultw one cycle after inputs; store visible to a load in the next cycle.
// Backpressure: none; the stage accepts one instruction every cycle, bubbles arrive as regwritem=0.
module memory_stage #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwritem,
    input  logic        memwritem,
    input  logic [1:0]  resultsrcm,
    input  logic [2:0]  funct3m,
    input  logic [31:0] solm,
    input  logic [31:0] regdatam,
    input  logic [4:0]  rdm,
    input  logic [4:0]  nxtaddm,
    output logic [31:0] memfwd,
    output logic        regwritew,
    output logic [4:0]  rdw,
    output logic [31:0] resultw,
    output logic        misalign_err
);

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              is_byte;
    logic              is_half;
    logic              is_load;
    logic              access_active;
    logic              misaligned;
    logic              store_en;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       wr_data;
    logic [31:0]       wr_mask;
    logic [31:0]       load_data;
    logic [31:0]       result_sel;

    // Upper address bits are dropped so the address space wraps modulo DEPTH words.
    assign word_idx = solm[ADDR_W+1:2];
    assign lane     = solm[1:0];

    // Size comes from funct3[1:0]; 01x and 11x encodings all fall through to word.
    assign is_byte = (funct3m[1:0] == 2'b00);
    assign is_half = (funct3m[1:0] == 2'b01);
    assign is_load = (resultsrcm == 2'b01);

    assign access_active = memwritem | is_load;
    assign misaligned    = access_active &
                           ((is_half & solm[0]) |
                            (!is_byte && !is_half && (solm[1:0] != 2'b00)));
    assign store_en      = memwritem & ~misaligned;

    assign memfwd   = solm;
    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    // Replicate store data across lanes and build the lane mask for the access size.
    always_comb begin
        wr_data = regdatam;
        wr_mask = 32'hFFFF_FFFF;
        if (is_byte) begin
            wr_data = {4{regdatam[7:0]}};
            wr_mask = 32'h0000_00FF << {lane, 3'b000};
        end else if (is_half) begin
            wr_data = {2{regdatam[15:0]}};
            wr_mask = 32'h0000_FFFF << {solm[1], 4'b0000};
        end
    end

    // Extract the addressed byte/halfword and extend; misaligned loads return zero.
    always_comb begin
        load_data = rd_word;
        if (is_byte) begin
            load_data = {{24{rd_shift[7] & ~funct3m[2]}}, rd_shift[7:0]};
        end else if (is_half) begin
            load_data = {{16{rd_shift[15] & ~funct3m[2]}}, rd_shift[15:0]};
        end
        if (misaligned) begin
            load_data = 32'h0000_0000;
        end
    end

    // Write-back source select.
    always_comb begin
        case (resultsrcm)
            2'b01:   result_sel = load_data;
            2'b10:   result_sel = {27'b0, nxtaddm};
            default: result_sel = solm;
        endcase
    end

    // Data memory: cleared by reset, masked lane write on aligned stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else if (store_en) begin
            mem[word_idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // MEM/WB register, loaded every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwritew <= 1'b0;
            rdw       <= 5'd0;
            resultw   <= 32'h0000_0000;
        end else begin
            regwritew <= regwritem;
            rdw       <= rdm;
            resultw   <= result_sel;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            misalign_err <= 1'b1;
        end
    end

endmodule
